// File: rtl/regular_ni_inject_gen.sv
// Regular-traffic injection controller: samples the sensor, builds a head/body/tail
// packet and writes it flit by flit into the NI injection FIFO under slot and full gating.
module regular_ni_inject_gen #(
   parameter int DATA_W      = 16,
   parameter int ADDR_W      = 4,
   parameter int PAYLOAD_LEN = 4,
   parameter int GAP_W       = 14,
   parameter int SEQ_W       = 8
) (
   input  logic              clk_division,
   input  logic              rst,
   input  logic              en,
   input  logic [ADDR_W-1:0] core_address,
   input  logic [ADDR_W-1:0] dest_address,
   input  logic [GAP_W-1:0]  inject_gap,
   input  logic [SEQ_W-1:0]  burst_len,
   input  logic              slot_valid,
   input  logic [DATA_W-3:0] sensor_data,
   input  logic              fifo_full,
   output logic              sample_en,
   output logic              fifo_wr,
   output logic [DATA_W-1:0] fifo_data,
   output logic [SEQ_W-1:0]  pkt_seq,
   output logic              busy,
   output logic              done
);

   localparam logic [2:0] IDLE   = 3'd0;
   localparam logic [2:0] SAMPLE = 3'd1;
   localparam logic [2:0] WAIT   = 3'd2;
   localparam logic [2:0] HEAD   = 3'd3;
   localparam logic [2:0] BODY   = 3'd4;
   localparam logic [2:0] GAP    = 3'd5;
   localparam logic [2:0] DONE   = 3'd6;

   localparam int IDX_W   = (PAYLOAD_LEN > 1) ? $clog2(PAYLOAD_LEN) : 1;
   localparam int SEQ_F_W = DATA_W - 2 - 2 * ADDR_W;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(PAYLOAD_LEN - 1);

   logic [2:0]        state_r;
   logic [2:0]        next_state_s;
   logic [2:0]        post_tail_s;
   logic [IDX_W-1:0]  flit_idx_r;
   logic [GAP_W-1:0]  gap_cnt_r;
   logic [GAP_W:0]    gap_cnt_next_s;
   logic              gap_done_s;
   logic [SEQ_W-1:0]  burst_cnt_r;
   logic [SEQ_W-1:0]  burst_next_s;
   logic [SEQ_W-1:0]  pkt_seq_r;
   logic [DATA_W-3:0] sample_r;
   logic              sample_en_r;
   logic              busy_r;
   logic              done_r;
   logic              wr_s;
   logic              tail_s;
   logic [SEQ_F_W-1:0] seq_field_s;
   logic [DATA_W-3:0] idx_ext_s;
   logic [DATA_W-1:0] fifo_data_s;

   // Head carries only the low bits of the sequence number that fit after the addresses.
   if (SEQ_W >= SEQ_F_W) begin : g_seq_trunc
      assign seq_field_s = pkt_seq_r[SEQ_F_W-1:0];
   end else begin : g_seq_ext
      assign seq_field_s = {{(SEQ_F_W - SEQ_W){1'b0}}, pkt_seq_r};
   end

   assign idx_ext_s      = {{(DATA_W - 2 - IDX_W){1'b0}}, flit_idx_r};
   assign wr_s           = ((state_r == HEAD) || (state_r == BODY)) && slot_valid && !fifo_full;
   assign tail_s         = (state_r == BODY) && wr_s && (flit_idx_r == LAST_IDX);
   assign burst_next_s   = burst_cnt_r + SEQ_W'(1);
   assign gap_cnt_next_s = {1'b0, gap_cnt_r} + (GAP_W + 1)'(1);
   assign gap_done_s     = (gap_cnt_next_s >= {1'b0, inject_gap});

   // Exit decision taken on the tail write; burst completion outranks a dropped enable.
   always_comb begin
      post_tail_s = IDLE;
      if ((burst_len != {SEQ_W{1'b0}}) && (burst_next_s == burst_len)) begin
         post_tail_s = DONE;
      end else if (!en) begin
         post_tail_s = IDLE;
      end else if (inject_gap == {GAP_W{1'b0}}) begin
         post_tail_s = SAMPLE;
      end else begin
         post_tail_s = GAP;
      end
   end

   // Next-state logic; a started packet always runs to its tail.
   always_comb begin
      next_state_s = state_r;
      case (state_r)
         IDLE:    if (en) next_state_s = SAMPLE; else next_state_s = IDLE;
         SAMPLE:  next_state_s = WAIT;
         WAIT:    next_state_s = HEAD;
         HEAD:    if (wr_s) next_state_s = BODY; else next_state_s = HEAD;
         BODY:    if (tail_s) next_state_s = post_tail_s; else next_state_s = BODY;
         GAP: begin
            if (!en) begin
               next_state_s = IDLE;
            end else if (gap_done_s) begin
               next_state_s = SAMPLE;
            end else begin
               next_state_s = GAP;
            end
         end
         DONE:    if (!en) next_state_s = IDLE; else next_state_s = DONE;
         default: next_state_s = IDLE;
      endcase
   end

   // Flit formatting; the bus is forced to zero whenever no write is issued.
   always_comb begin
      fifo_data_s = {DATA_W{1'b0}};
      if (wr_s && (state_r == HEAD)) begin
         fifo_data_s = {2'b10, dest_address, core_address, seq_field_s};
      end else if (wr_s) begin
         fifo_data_s[DATA_W-1:DATA_W-2] = (flit_idx_r == LAST_IDX) ? 2'b01 : 2'b00;
         fifo_data_s[DATA_W-3:0] = (flit_idx_r == {IDX_W{1'b0}}) ? sample_r : idx_ext_s;
      end else begin
         fifo_data_s = {DATA_W{1'b0}};
      end
   end

   // State register and registered status outputs derived from the next state.
   always_ff @(posedge clk_division or negedge rst) begin
      if (!rst) begin
         state_r     <= IDLE;
         sample_en_r <= 1'b0;
         busy_r      <= 1'b0;
         done_r      <= 1'b0;
      end else begin
         state_r     <= next_state_s;
         sample_en_r <= (next_state_s == SAMPLE);
         busy_r      <= (next_state_s != IDLE) && (next_state_s != DONE);
         done_r      <= (next_state_s == DONE);
      end
   end

   // Packet datapath: sample capture, flit index, gap timer, burst and sequence counters.
   always_ff @(posedge clk_division or negedge rst) begin
      if (!rst) begin
         flit_idx_r  <= {IDX_W{1'b0}};
         gap_cnt_r   <= {GAP_W{1'b0}};
         burst_cnt_r <= {SEQ_W{1'b0}};
         pkt_seq_r   <= {SEQ_W{1'b0}};
         sample_r    <= {(DATA_W - 2){1'b0}};
      end else begin
         if (state_r == WAIT) sample_r <= sensor_data;
         if (state_r == HEAD) begin
            flit_idx_r <= {IDX_W{1'b0}};
         end else if ((state_r == BODY) && wr_s) begin
            flit_idx_r <= tail_s ? {IDX_W{1'b0}} : flit_idx_r + IDX_W'(1);
         end
         if (state_r == GAP) gap_cnt_r <= gap_cnt_next_s[GAP_W-1:0];
         else                gap_cnt_r <= {GAP_W{1'b0}};
         if (state_r == IDLE) burst_cnt_r <= {SEQ_W{1'b0}};
         else if (tail_s)     burst_cnt_r <= burst_next_s;
         if (tail_s) pkt_seq_r <= pkt_seq_r + SEQ_W'(1);
      end
   end

   assign sample_en = sample_en_r;
   assign fifo_wr   = wr_s;
   assign fifo_data = fifo_data_s;
   assign pkt_seq   = pkt_seq_r;
   assign busy      = busy_r;
   assign done      = done_r;

endmodule

// File: tb/tb_regular_ni_inject_gen.sv
// Scoreboard bench for regular_ni_inject_gen: stimulus queues expected flits,
// a negedge monitor pops and compares every FIFO write.
module tb_regular_ni_inject_gen;

   logic        clk_division;
   logic        rst;
   logic        en;
   logic [3:0]  core_address;
   logic [3:0]  dest_address;
   logic [13:0] inject_gap;
   logic [7:0]  burst_len;
   logic        slot_valid;
   logic [13:0] sensor_data;
   logic        fifo_full;
   logic        sample_en;
   logic        fifo_wr;
   logic [15:0] fifo_data;
   logic [7:0]  pkt_seq;
   logic        busy;
   logic        done;

   int          pass_cnt = 0;
   int          total_cnt = 0;
   int          wr_cnt = 0;
   int          wr_mark;
   logic [15:0] exp_q[$];

   regular_ni_inject_gen dut (
      .clk_division(clk_division), .rst(rst), .en(en),
      .core_address(core_address), .dest_address(dest_address),
      .inject_gap(inject_gap), .burst_len(burst_len), .slot_valid(slot_valid),
      .sensor_data(sensor_data), .fifo_full(fifo_full), .sample_en(sample_en),
      .fifo_wr(fifo_wr), .fifo_data(fifo_data), .pkt_seq(pkt_seq),
      .busy(busy), .done(done)
   );

   initial clk_division = 1'b0;
   always #5 clk_division = ~clk_division;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total_cnt++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
   endtask

   task automatic step();
      @(posedge clk_division);
      #2;
   endtask

   // core=3, dest=9: head = {2'b10, 4'd9, 4'd3, seq[5:0]}
   function automatic logic [15:0] head_f(input logic [7:0] s);
      return {2'b10, 4'd9, 4'd3, s[5:0]};
   endfunction

   task automatic push_pkt(input logic [7:0] s, input logic [13:0] smp);
      exp_q.push_back(head_f(s));
      exp_q.push_back({2'b00, smp});
      exp_q.push_back(16'h0001);
      exp_q.push_back(16'h0002);
      exp_q.push_back(16'h4003);
   endtask

   // Monitor: every write must match the head of the scoreboard; idle bus must be zero.
   always @(negedge clk_division) begin
      if (rst) begin
         if (fifo_wr) begin
            wr_cnt++;
            if (exp_q.size() == 0) begin
               total_cnt++;
               $display("FAIL unexpected_write: got 0x%0h, expected no write", fifo_data);
            end else begin
               chk("flit", {16'h0000, fifo_data}, {16'h0000, exp_q.pop_front()});
            end
         end else begin
            chk("idle_data", {16'h0000, fifo_data}, 32'h0);
         end
      end
   end

   initial begin
      rst = 1'b0; en = 1'b0; core_address = 4'd3; dest_address = 4'd9;
      inject_gap = 14'd2; burst_len = 8'd1; slot_valid = 1'b1;
      sensor_data = 14'h0000; fifo_full = 1'b0;
      #12;
      chk("rst_wr", fifo_wr, 1'b0);
      chk("rst_data", fifo_data, 16'h0000);
      chk("rst_seq", pkt_seq, 8'h00);
      chk("rst_busy", busy, 1'b0);
      chk("rst_done", done, 1'b0);
      chk("rst_sample_en", sample_en, 1'b0);
      step(); rst = 1'b1; step();

      // 1: single-packet burst
      exp_q.push_back(16'hA4C0); exp_q.push_back(16'h0155); exp_q.push_back(16'h0001);
      exp_q.push_back(16'h0002); exp_q.push_back(16'h4003);
      wr_mark = wr_cnt;
      en = 1'b1;
      step(); chk("t1_sample_en", sample_en, 1'b1); chk("t1_busy", busy, 1'b1);
      sensor_data = 14'h0155;
      step(); chk("t1_wait_sample_en", sample_en, 1'b0); chk("t1_wait_wr", fifo_wr, 1'b0);
      for (int i = 0; i < 5; i++) begin
         step(); chk("t1_wr_cycle", fifo_wr, 1'b1);
      end
      step();
      chk("t1_done", done, 1'b1); chk("t1_seq", pkt_seq, 8'd1);
      chk("t1_busy_done", busy, 1'b0); chk("t1_wr_count", wr_cnt - wr_mark, 5);
      step(); chk("t1_done_held", done, 1'b1);
      en = 1'b0;
      step(); chk("t1_done_clear", done, 1'b0);

      // 2: continuous, gap 0, period 7, seq wrap; en dropped at last head (5)
      burst_len = 8'd0; inject_gap = 14'd0; sensor_data = 14'h02AA; en = 1'b1;
      for (int s = 1; s <= 255; s++) push_pkt(8'(s), 14'h02AA);
      step(); chk("t2_sample_en", sample_en, 1'b1);
      step(); step();
      for (int k = 0; k < 255; k++) begin
         chk("t2_head_wr", fifo_wr, 1'b1);
         chk("t2_head_type", fifo_data[15:14], 2'b10);
         if (k == 254) en = 1'b0;
         else repeat (7) step();
      end
      repeat (5) step();
      chk("t5_idle_busy", busy, 1'b0); chk("t2_seq_wrap", pkt_seq, 8'd0);
      chk("t5_idle_sample_en", sample_en, 1'b0);
      step(); chk("t5_no_restart", sample_en, 1'b0); chk("t2_q_empty", exp_q.size(), 0);

      // 3: fifo_full for 3 cycles at body index 1
      burst_len = 8'd1; sensor_data = 14'h00AB; en = 1'b1;
      push_pkt(8'd0, 14'h00AB);
      wr_mark = wr_cnt;
      step(); step(); step(); step();
      step(); fifo_full = 1'b1; #1;
      chk("t3_stall_wr", fifo_wr, 1'b0); chk("t3_stall_data", fifo_data, 16'h0000);
      step(); chk("t3_stall_wr", fifo_wr, 1'b0);
      step(); chk("t3_stall_wr", fifo_wr, 1'b0);
      step(); fifo_full = 1'b0; #1; chk("t3_resume", fifo_data, 16'h0001);
      step(); step(); step();
      chk("t3_done", done, 1'b1); chk("t3_seq", pkt_seq, 8'd1);
      chk("t3_wr_count", wr_cnt - wr_mark, 5);
      en = 1'b0; step();

      // 4: slot_valid toggling
      sensor_data = 14'h1234; en = 1'b1;
      push_pkt(8'd1, 14'h1234);
      wr_mark = wr_cnt;
      for (int c = 0; c < 40; c++) begin
         step();
         slot_valid = ~slot_valid;
         #1;
         if (!slot_valid) chk("t4_gated", fifo_wr, 1'b0);
         if (done) break;
      end
      chk("t4_done", done, 1'b1); chk("t4_seq", pkt_seq, 8'd2);
      chk("t4_wr_count", wr_cnt - wr_mark, 5);
      slot_valid = 1'b1; en = 1'b0; step();

      // 5: en dropped in GAP
      burst_len = 8'd0; inject_gap = 14'd5; sensor_data = 14'h0777; en = 1'b1;
      push_pkt(8'd2, 14'h0777);
      step(); chk("t5_sample_en", sample_en, 1'b1);
      repeat (6) step();
      step(); chk("t5_gap_busy", busy, 1'b1); chk("t5_gap_wr", fifo_wr, 1'b0);
      en = 1'b0;
      step(); chk("t5_gap_idle", busy, 1'b0); chk("t5_gap_no_sample", sample_en, 1'b0);
      step(); chk("t5_gap_no_sample2", sample_en, 1'b0); chk("t5_seq", pkt_seq, 8'd3);

      // 6: reset mid-BODY
      inject_gap = 14'd0; sensor_data = 14'h0042; en = 1'b1;
      exp_q.push_back(head_f(8'd3)); exp_q.push_back(16'h0042); exp_q.push_back(16'h0001);
      step(); step(); step(); step(); step();
      chk("t6_body_busy", busy, 1'b1);
      @(negedge clk_division); #1; rst = 1'b0; #1;
      chk("t6_rst_wr", fifo_wr, 1'b0); chk("t6_rst_data", fifo_data, 16'h0000);
      chk("t6_rst_seq", pkt_seq, 8'd0); chk("t6_rst_busy", busy, 1'b0);
      #1; rst = 1'b1;
      step(); chk("t6_restart_sample_en", sample_en, 1'b1);
      chk("t6_q_empty", exp_q.size(), 0);
      rst = 1'b0; #3;

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
